// File: rtl/lb_pkg.sv
// lb_pkg: shared defaults and row-length clamping for the line buffer
package lb_pkg;
    localparam int DATA_W_D  = 8;
    localparam int MAX_LEN_D = 109;
    localparam int ROWS_D    = 2;

    function automatic int clamp_len(input int len, input int max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction
endpackage

// File: rtl/lb_if.sv
// lb_if: pixel stream in, aligned vertical taps out
interface lb_if
    import lb_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int ROWS   = ROWS_D,
    parameter int LEN_W  = $clog2(MAX_LEN_D + 1)
);
    logic                         clear_i;
    logic [LEN_W-1:0]             row_len_i;
    logic                         valid_i;
    logic [DATA_W-1:0]            data_i;
    logic                         valid_o;
    logic [(ROWS+1)*DATA_W-1:0]   taps_o;
    logic [ROWS:0]                row_ok_o;
    logic                         full_o;

    modport master (output clear_i, row_len_i, valid_i, data_i,
                    input  valid_o, taps_o, row_ok_o, full_o);
    modport slave  (input  clear_i, row_len_i, valid_i, data_i,
                    output valid_o, taps_o, row_ok_o, full_o);
endinterface

// File: rtl/lb_row_ram.sv
// lb_row_ram: one row of pixel storage; combinational read returns the pre-write word
module lb_row_ram #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 109,
    parameter int AW      = 7
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MAX_LEN];

    assign rdata = mem[addr];

    always_ff @(posedge clk)
        if (en) mem[addr] <= wdata;
endmodule

// File: rtl/line_buffer_taps.sv
// line_buffer_taps: chained row RAMs sharing one pointer, presenting ROWS+1 aligned taps
module line_buffer_taps
    import lb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int MAX_LEN = MAX_LEN_D,
    parameter int ROWS    = ROWS_D,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input logic clk,
    input logic rst_n,
    lb_if.slave bus
);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic [LEN_W-1:0]           ptr, len_q;
    logic [CNT_W-1:0]           row_cnt;
    logic [DATA_W-1:0]          old [ROWS];
    logic [(ROWS+1)*DATA_W-1:0] taps_d;
    logic [ROWS:0]              ok_d;
    logic                       acc, last;

    assign acc  = bus.valid_i & ~bus.clear_i;
    assign last = ptr == len_q - LEN_W'(1);
    assign taps_d[DATA_W-1:0] = bus.data_i;
    assign ok_d[0] = 1'b1;

    // RAM g holds the row g+1 lines back; each pushes its evicted word into the next
    for (genvar g = 0; g < ROWS; g++) begin : g_row
        lb_row_ram #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .AW(LEN_W)) u_ram (
            .clk  (clk),
            .en   (acc),
            .addr (ptr),
            .wdata(g == 0 ? bus.data_i : old[g == 0 ? 0 : g-1]),
            .rdata(old[g])
        );
        assign ok_d[g+1] = row_cnt > CNT_W'(g);
        assign taps_d[(g+1)*DATA_W +: DATA_W] = ok_d[g+1] ? old[g] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear_i) begin
            ptr          <= '0;
            row_cnt      <= '0;
            len_q        <= !rst_n ? LEN_W'(MAX_LEN) : LEN_W'(clamp_len(int'(bus.row_len_i), MAX_LEN));
            bus.valid_o  <= 1'b0;
            bus.taps_o   <= '0;
            bus.row_ok_o <= '0;
            bus.full_o   <= 1'b0;
        end else begin
            bus.valid_o <= acc;
            if (acc) begin
                ptr          <= last ? '0 : ptr + LEN_W'(1);
                if (last && row_cnt != CNT_W'(ROWS)) row_cnt <= row_cnt + CNT_W'(1);
                bus.taps_o   <= taps_d;
                bus.row_ok_o <= ok_d;
                bus.full_o   <= row_cnt == CNT_W'(ROWS);
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_taps.sv
// tb_line_buffer_taps: directed stream with a history-based scoreboard of expected taps
module tb_line_buffer_taps;
    localparam int DW = 8, ML = 109, R = 2, LW = $clog2(ML + 1);

    typedef struct packed {
        logic [(R+1)*DW-1:0] taps;
        logic [R:0]          ok;
        logic                full;
    } exp_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    lb_if #(.DATA_W(DW), .ROWS(R), .LEN_W(LW)) bus ();
    line_buffer_taps #(.DATA_W(DW), .MAX_LEN(ML), .ROWS(R), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0, errors = 0;
    exp_t sb[$];
    exp_t held;
    logic [DW-1:0] hist [1024];
    int cnt, len;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // tap k of beat p is the pixel pushed k*len beats earlier, if one exists
    function automatic exp_t model(int p);
        exp_t e = '0;
        e.taps[DW-1:0] = hist[p];
        e.ok[0] = 1'b1;
        for (int k = 1; k <= R; k++) begin
            e.ok[k] = p >= k * len;
            if (e.ok[k]) e.taps[k*DW +: DW] = hist[p - k*len];
        end
        e.full = p >= R * len;
        return e;
    endfunction

    task automatic check_all(string tag, bit v);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'(v));
        chk({tag, "_taps"},  32'(bus.taps_o), 32'(held.taps));
        chk({tag, "_ok"},    32'(bus.row_ok_o), 32'(held.ok));
        chk({tag, "_full"},  32'(bus.full_o), 32'(held.full));
    endtask

    task automatic step(bit v, logic [DW-1:0] d);
        bus.valid_i = v;
        bus.data_i  = d;
        if (v) begin
            hist[cnt] = d;
            sb.push_back(model(cnt));
            cnt++;
        end
        @(posedge clk); #1;
        bus.valid_i = 0;
        if (v) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard observed=empty expected=entry");
            end
            if (sb.size() > 0) held = sb.pop_front();
        end
        check_all("beat", v);
    endtask

    task automatic restart(int new_len);
        cnt  = 0;
        len  = new_len;
        held = '0;
        sb.delete();
        check_all("restart", 1'b0);
    endtask

    task automatic do_clear(logic [LW-1:0] rl, bit v, logic [DW-1:0] d);
        bus.clear_i   = 1;
        bus.row_len_i = rl;
        bus.valid_i   = v;
        bus.data_i    = d;
        @(posedge clk); #1;
        bus.clear_i = 0;
        bus.valid_i = 0;
        restart((rl == 0 || int'(rl) > ML) ? ML : int'(rl));
    endtask

    task automatic do_reset(bit v, logic [DW-1:0] d);
        rst_n         = 0;
        bus.valid_i   = v;
        bus.data_i    = d;
        bus.row_len_i = 4;
        @(posedge clk); #1;
        rst_n       = 1;
        bus.valid_i = 0;
        restart(ML);
    endtask

    initial begin
        bus.clear_i = 0; bus.valid_i = 0; bus.data_i = 0; bus.row_len_i = 4;
        do_reset(0, 0);

        do_clear(4, 0, 0);
        for (int n = 0; n < 12; n++) step(1, 8'(n));

        do_clear(4, 0, 0);
        for (int n = 0; n < 6; n++) step(1, 8'(n));
        for (int i = 0; i < 3; i++) step(0, 0);
        chk("gap_hold", 32'(bus.taps_o), 32'h000105);
        for (int n = 6; n < 12; n++) step(1, 8'(n));

        do_clear(109, 0, 0);
        for (int n = 0; n < 300; n++) begin
            step(1, 8'(n));
            if (n == 250) begin
                chk("n250_tap1", 32'(bus.taps_o[15:8]), 32'h8D);
                chk("n250_tap2", 32'(bus.taps_o[23:16]), 32'd32);
            end
        end

        do_clear(3, 0, 0);
        for (int n = 0; n < 7; n++) step(1, 8'(n));
        do_clear(3, 1, 8'd7);
        step(1, 8'h50);
        chk("after_clear_ok", 32'(bus.row_ok_o), 32'b001);
        for (int n = 1; n < 4; n++) step(1, 8'(n));
        chk("after_clear_tap1", 32'(bus.taps_o[15:8]), 32'h50);

        do_clear(0, 0, 0);
        for (int n = 0; n < 110; n++) step(1, 8'(n + 1));
        chk("len0_tap1", 32'(bus.taps_o[15:8]), 32'd1);
        do_clear(127, 0, 0);
        for (int n = 0; n < 110; n++) step(1, 8'(n + 1));
        chk("len127_tap1", 32'(bus.taps_o[15:8]), 32'd1);

        do_clear(4, 0, 0);
        for (int n = 0; n < 6; n++) step(1, 8'(n));
        do_reset(1, 8'd6);
        step(1, 8'h11);
        chk("post_reset_ok", 32'(bus.row_ok_o), 32'b001);
        for (int n = 0; n < 6; n++) step(1, 8'(n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
